// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: parity encoding, FSM states
// and frame-geometry helpers.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } tx_state_e;

  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

  function automatic int baud_cnt_width(input int clk_div);
    return (clk_div <= 2) ? 1 : $clog2(clk_div);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO, registered count; read data is the head entry, valid while not empty.
// Push when full and pop when empty are ignored; a pop frees a slot only from the next cycle.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign push_ok    = push_i && !full_o;
  assign pop_ok     = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/uart_tx_stream.sv
// UART transmitter fed by a valid/ready byte stream through a small FIFO.
// txd falls one edge after a word enters an empty idle block; s_ready_o drops only when the FIFO is full.
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 868,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  input  logic [DATA_BITS-1:0]          s_data_i,
  output logic                          txd_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_clk_div
    $error("uart_tx_stream: CLK_DIV out of range");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_stream: DATA_BITS out of range");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
    $error("uart_tx_stream: illegal PARITY");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_stream: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_stream: FIFO_DEPTH must be a power of two >= 2");
  end

  localparam int                BAUD_W    = baud_cnt_width(CLK_DIV);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);

  tx_state_e             state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [3:0]            bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  txd_q, txd_d;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0]  fifo_data;
  logic                  bit_end, load;

  assign s_ready_o = !fifo_full;
  assign fifo_push = s_valid_i && s_ready_o;
  assign txd_o     = txd_q;
  assign busy_o    = (state_q != IDLE) || !fifo_empty;
  assign bit_end   = (baud_q == BAUD_LAST);

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (fifo_push),
    .push_data_i (s_data_i),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count_o)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!fifo_empty) state_d = START;
      START: if (bit_end) state_d = DATA;
      DATA:  if (bit_end && bit_q == DATA_LAST) state_d = (PARITY != PAR_NONE) ? PAR : STOP;
      PAR:   if (bit_end) state_d = STOP;
      STOP:  if (bit_end && bit_q == STOP_LAST) state_d = fifo_empty ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  // Entering START from IDLE or straight out of STOP both pop the next word.
  assign load = (state_d == START) && (state_q != START);

  always_comb begin
    fifo_pop = load;
    baud_d   = (state_q == IDLE || bit_end) ? '0 : baud_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    txd_d    = txd_q;
    if (load) begin
      shift_d = fifo_data;
      par_d   = (PARITY == PAR_ODD) ? ~^fifo_data : ^fifo_data;
      bit_d   = '0;
      txd_d   = 1'b0;
    end else if (bit_end) begin
      case (state_q)
        START: begin
          bit_d = '0;
          txd_d = shift_q[0];
        end
        DATA: begin
          if (state_d == DATA) begin
            bit_d   = bit_q + 4'd1;
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
          end else begin
            bit_d = '0;
            txd_d = (state_d == PAR) ? par_q : 1'b1;
          end
        end
        PAR: begin
          bit_d = '0;
          txd_d = 1'b1;
        end
        STOP: begin
          bit_d = bit_q + 4'd1;
          txd_d = 1'b1;
        end
        default: txd_d = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed bench for uart_tx_stream at CLK_DIV=4 across 8N1, 8E1, 8O1 and 7N2 frames.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_uart_tx_stream;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic       a_valid, a_ready, a_txd, a_busy;
  logic [7:0] a_data;
  logic [2:0] a_cnt;
  logic       e_valid, e_ready, e_txd, e_busy;
  logic [7:0] e_data;
  logic [2:0] e_cnt;
  logic       o_valid, o_ready, o_txd, o_busy;
  logic [7:0] o_data;
  logic [2:0] o_cnt;
  logic       s_valid, s_ready, s_txd, s_busy;
  logic [6:0] s_data;
  logic [2:0] s_cnt;

  uart_tx_stream #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk_i(clk), .reset_i(rst), .s_valid_i(a_valid), .s_ready_o(a_ready), .s_data_i(a_data),
    .txd_o(a_txd), .busy_o(a_busy), .fifo_count_o(a_cnt));
  uart_tx_stream #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_e (
    .clk_i(clk), .reset_i(rst), .s_valid_i(e_valid), .s_ready_o(e_ready), .s_data_i(e_data),
    .txd_o(e_txd), .busy_o(e_busy), .fifo_count_o(e_cnt));
  uart_tx_stream #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_o (
    .clk_i(clk), .reset_i(rst), .s_valid_i(o_valid), .s_ready_o(o_ready), .s_data_i(o_data),
    .txd_o(o_txd), .busy_o(o_busy), .fifo_count_o(o_cnt));
  uart_tx_stream #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_s (
    .clk_i(clk), .reset_i(rst), .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
    .txd_o(s_txd), .busy_o(s_busy), .fifo_count_o(s_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_valid = 0; e_valid = 0; o_valid = 0; s_valid = 0;
    a_data = '0; e_data = '0; o_data = '0; s_data = '0;
    step();
    step();
    rst = 1'b0;
    step();
    total++; if (a_txd !== 1'b1)  begin bad++; $display("FAIL reset_txd: got %b want 1", a_txd); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", a_busy); end
    total++; if (a_cnt !== 3'd0)  begin bad++; $display("FAIL reset_count: got %0d want 0", a_cnt); end
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", a_ready); end
    total++; if ({e_txd, o_txd, s_txd} !== 3'b111) begin bad++; $display("FAIL reset_txd_others: got %b want 111", {e_txd, o_txd, s_txd}); end
  endtask

  task automatic test_8n1();
    logic [9:0] exp;
    exp = 10'b1010101010;
    a_valid = 1'b1; a_data = 8'h55;
    step();
    a_valid = 1'b0;
    total++; if (a_txd !== 1'b1) begin bad++; $display("FAIL 8n1_no_early_start: got %b want 1", a_txd); end
    total++; if (a_cnt !== 3'd1) begin bad++; $display("FAIL 8n1_count_after_accept: got %0d want 1", a_cnt); end
    total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL 8n1_busy_after_accept: got %b want 1", a_busy); end
    step();
    for (int i = 0; i < 40; i++) begin
      total++;
      if (a_txd !== exp[i/4]) begin bad++; $display("FAIL 8n1_line clk %0d: got %b want %b", i, a_txd, exp[i/4]); end
      if (i == 39) begin
        total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL 8n1_busy_last_stop: got %b want 1", a_busy); end
      end
      step();
    end
    total++; if (a_txd !== 1'b1)  begin bad++; $display("FAIL 8n1_idle_txd: got %b want 1", a_txd); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL 8n1_busy_drop: got %b want 0", a_busy); end
  endtask

  task automatic test_parity();
    logic [10:0] exp_e, exp_o;
    exp_e = 11'b11000001110;
    exp_o = 11'b10000001110;
    e_valid = 1'b1; e_data = 8'h07;
    o_valid = 1'b1; o_data = 8'h07;
    step();
    e_valid = 1'b0; o_valid = 1'b0;
    step();
    for (int i = 0; i < 44; i++) begin
      total++;
      if (e_txd !== exp_e[i/4]) begin bad++; $display("FAIL 8e1_line clk %0d: got %b want %b", i, e_txd, exp_e[i/4]); end
      total++;
      if (o_txd !== exp_o[i/4]) begin bad++; $display("FAIL 8o1_line clk %0d: got %b want %b", i, o_txd, exp_o[i/4]); end
      if (i == 43) begin
        total++; if ({e_busy, o_busy} !== 2'b11) begin bad++; $display("FAIL parity_busy_last_stop: got %b want 11", {e_busy, o_busy}); end
      end
      step();
    end
    total++; if ({e_busy, o_busy} !== 2'b00) begin bad++; $display("FAIL parity_busy_drop: got %b want 00", {e_busy, o_busy}); end
  endtask

  task automatic test_7n2_back_to_back();
    logic [19:0] exp;
    exp = {10'b1100000000, 10'b1111111110};
    s_valid = 1'b1; s_data = 7'h7F;
    step();
    total++; if (s_cnt !== 3'd1) begin bad++; $display("FAIL 7n2_count_first: got %0d want 1", s_cnt); end
    s_data = 7'h00;
    step();
    s_valid = 1'b0;
    total++; if (s_cnt !== 3'd1) begin bad++; $display("FAIL 7n2_count_push_pop: got %0d want 1", s_cnt); end
    for (int i = 0; i < 80; i++) begin
      total++;
      if (s_txd !== exp[i/4]) begin bad++; $display("FAIL 7n2_line clk %0d: got %b want %b", i, s_txd, exp[i/4]); end
      if (i == 40) begin
        total++; if (s_cnt !== 3'd0) begin bad++; $display("FAIL 7n2_second_popped: got %0d want 0", s_cnt); end
      end
      step();
    end
    total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL 7n2_busy_drop: got %b want 0", s_busy); end
  endtask

  task automatic test_fifo_fill();
    logic [9:0] f;
    int accepted;
    logic [2:0] peak;
    accepted = 0;
    peak = '0;
    for (int t = 0; t < 202; t++) begin
      if (t < 6) begin
        a_valid = 1'b1;
        a_data  = 8'(t + 1);
        total++;
        if (a_ready !== (t < 5)) begin bad++; $display("FAIL fill_ready cycle %0d: got %b want %b", t, a_ready, (t < 5)); end
        if (a_ready === 1'b1) accepted++;
      end else begin
        a_valid = 1'b0;
      end
      step();
      if (a_cnt > peak) peak = a_cnt;
      if (t >= 1 && t <= 200) begin
        f = {1'b1, 8'((t - 1) / 40 + 1), 1'b0};
        total++;
        if (a_txd !== f[((t - 1) % 40) / 4]) begin
          bad++; $display("FAIL fill_line clk %0d: got %b want %b", t - 1, a_txd, f[((t - 1) % 40) / 4]);
        end
      end
    end
    total++; if (accepted != 5) begin bad++; $display("FAIL fill_accepted: got %0d want 5", accepted); end
    total++; if (peak !== 3'd4) begin bad++; $display("FAIL fill_peak_count: got %0d want 4", peak); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL fill_busy_drop: got %b want 0", a_busy); end
    total++; if (a_cnt !== 3'd0) begin bad++; $display("FAIL fill_final_count: got %0d want 0", a_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] seq [3];
    int stray;
    seq = '{8'hA1, 8'hB2, 8'hC3};
    stray = 0;
    for (int t = 0; t < 49; t++) begin
      a_valid = (t < 3);
      a_data  = (t < 3) ? seq[t] : 8'h00;
      step();
    end
    a_valid = 1'b0;
    total++; if (a_txd !== 1'b0) begin bad++; $display("FAIL midframe_txd_before: got %b want 0", a_txd); end
    total++; if (a_cnt !== 3'd1) begin bad++; $display("FAIL midframe_count_before: got %0d want 1", a_cnt); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (a_txd !== 1'b1)  begin bad++; $display("FAIL midframe_txd_after_reset: got %b want 1", a_txd); end
    total++; if (a_cnt !== 3'd0)  begin bad++; $display("FAIL midframe_count_after_reset: got %0d want 0", a_cnt); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL midframe_busy_after_reset: got %b want 0", a_busy); end
    for (int i = 0; i < 120; i++) begin
      if (a_txd !== 1'b1 || a_busy !== 1'b0) stray++;
      step();
    end
    total++; if (stray != 0) begin bad++; $display("FAIL midframe_stray_activity: got %0d cycles want 0", stray); end
    a_valid = 1'b1; a_data = 8'h3C;
    step();
    a_valid = 1'b0;
    total++; if (a_txd !== 1'b1) begin bad++; $display("FAIL midframe_new_accept_txd: got %b want 1", a_txd); end
    step();
    total++; if (a_txd !== 1'b0) begin bad++; $display("FAIL midframe_new_start_bit: got %b want 0", a_txd); end
    for (int i = 0; i < 40; i++) step();
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL midframe_new_frame_end: got %b want 0", a_busy); end
  endtask

  task automatic test_push_pop_same();
    logic [7:0] seq [4];
    logic [9:0] f;
    seq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    for (int t = 0; t < 162; t++) begin
      a_valid = 1'b0;
      if (t < 3) begin
        a_valid = 1'b1; a_data = seq[t];
      end else if (t == 41) begin
        a_valid = 1'b1; a_data = seq[3];
      end
      step();
      if (t == 40 || t == 41) begin
        total++; if (a_cnt !== 3'd2) begin bad++; $display("FAIL pushpop_count t=%0d: got %0d want 2", t, a_cnt); end
      end
      if (t >= 1 && t <= 160) begin
        f = {1'b1, seq[(t - 1) / 40], 1'b0};
        total++;
        if (a_txd !== f[((t - 1) % 40) / 4]) begin
          bad++; $display("FAIL pushpop_line clk %0d: got %b want %b", t - 1, a_txd, f[((t - 1) % 40) / 4]);
        end
      end
    end
    a_valid = 1'b0;
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL pushpop_busy_drop: got %b want 0", a_busy); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_8n1();
    test_parity();
    test_7n2_back_to_back();
    test_fifo_fill();
    test_reset_mid_frame();
    test_push_pop_same();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_stream.md
Name: uart_tx_stream

Overview:
Parametrised UART transmitter with a valid/ready byte-stream input and an internal FIFO. Frame format is configurable: data width, parity mode and stop-bit count. Bit period is set by a clock-divider parameter. Sits between on-chip producers (crypto core result path, debug dumps) and the board TxD pin. Supports back-to-back frames with no idle gap.

Parameters:
CLK_DIV, 868, clocks per bit (100 MHz / 115200); legal range 2..65535
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame; legal values 1 or 2
FIFO_DEPTH, 4, input FIFO entries; power of two, at least 2

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
s_valid  in  1  producer has a word on s_data
s_ready  out  1  block can accept a word (high when FIFO not full)
s_data  in  DATA_BITS  word to send, LSB transmitted first
txd  out  1  serial output, registered; idles high
busy  out  1  frame in progress or FIFO non-empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries currently stored

Behaviour:
- Reset values: txd=1, busy=0, fifo_count=0, s_ready=1 in the cycle after reset deasserts; FSM=IDLE, baud and bit counters=0.
- Handshake:
  - A word is accepted at any rising edge with s_valid && s_ready.
  - s_ready = !full; it is combinational from the FIFO count only and never depends on s_valid.
  - Push and pop in the same cycle leave the count unchanged.
  - When full, there is no pass-through: a pop frees a slot visible from the next cycle.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: if the FIFO is non-empty, pop, load the shift register, go to START, and drive txd=0 from that edge.
  - START: one bit period at 0, then go to DATA.
  - DATA: DATA_BITS periods, LSB first. After the last bit, go to PAR if PARITY!=0, else STOP.
  - PAR: one period. Even parity bit = XOR of the data bits; odd parity bit = its inverse.
  - STOP: STOP_BITS periods at 1. At the end, if the FIFO is non-empty, pop and go directly to START (no idle bit); else go to IDLE with txd=1.
- Timing:
  - Each bit is held exactly CLK_DIV clocks.
  - The baud counter runs 0..CLK_DIV-1 and restarts at 0 on every frame start, so frames are phase-independent.
  - Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLK_DIV clocks.
- Latency: word accepted at edge k into an empty FIFO while IDLE → popped at edge k+1 → txd falls at edge k+1.
- busy is high from the cycle fifo_count becomes non-zero until the FSM returns to IDLE with the FIFO empty.
- Reset mid-frame: on the next edge txd=1, the frame is abandoned with no completion, the FIFO is flushed, and all counters clear.
- The data word is latched at pop. s_data is not sampled after acceptance.
- Illegal parameter values are rejected by elaboration-time assertions.

Decomposition:
- Package uart_pkg:
  - parity encoding constants PAR_NONE/PAR_ODD/PAR_EVEN
  - FSM state typedef
  - function frame_bits(DATA_BITS, PARITY, STOP_BITS)
  - function for the baud counter width
- Sub-module uart_tx_fifo: synchronous FIFO, parametrised width/depth, with push/pop/full/empty/count outputs. It is reused by the planned receiver.
- Top contains the FSM, baud counter, bit counter and shift register.

Test Plan:
- CLK_DIV=4, 8N1, send 0x55 → txd = 0,1,0,1,0,1,0,1,0,1; each level lasts 4 clocks; 40 clocks total; txd falls 1 edge after acceptance; busy drops on the cycle txd returns to idle.
- CLK_DIV=4, 8E1, send 0x07 → parity bit=1, frame 44 clocks. Same test with PARITY=1 (odd) → parity bit=0.
- CLK_DIV=4, 7N2, send 0x7F → start 0, seven 1s, two stop 1s, total 40 clocks; next frame begins immediately after the second stop bit.
- FIFO_DEPTH=4, s_valid held 6 cycles with bytes 0x01..0x06:
  - exactly 5 accepted (0x01..0x05); s_ready low from the 6th cycle
  - 5 contiguous frames, 200 clocks total, no idle gap
  - fifo_count peaks at 4
- Reset asserted mid-DATA of the 2nd of 3 queued frames → next edge: txd=1, fifo_count=0, busy=0; no further start bit appears until a new word is accepted.
- Push and pop same cycle with fifo_count=2 → fifo_count stays 2; word order preserved on the line.
